// File: rtl/sync_updown_mod_counter.sv
// Synchronous up/down counter with programmable modulus, clamped parallel load,
// wrap or saturate at the bounds, combinational terminal count and sticky overflow.
module sync_updown_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             E,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP,
    output logic             OVF
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("sync_updown_mod_counter: WIDTH must be in 2..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("sync_updown_mod_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (SATURATE != 0 && SATURATE != 1) begin : g_bad_saturate
        $error("sync_updown_mod_counter: SATURATE must be 0 or 1");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             at_top, at_bottom, at_bound;

    assign at_top    = (count_q == MAX_VAL);
    assign at_bottom = (count_q == '0);
    assign at_bound  = UP ? at_top : at_bottom;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (CLR) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (LD) begin
            count_d = (D > MAX_VAL) ? MAX_VAL : D;
            ovf_d   = 1'b0;
        end else if (E) begin
            if (at_bound) begin
                // Saturate mode flags the overflow but leaves the count parked.
                ovf_d = 1'b1;
                if (SATURATE == 0) begin
                    count_d = UP ? '0 : MAX_VAL;
                    wrap_d  = 1'b1;
                end
            end else if (UP) begin
                count_d = count_q + 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        count_q <= count_d;
        wrap_q  <= wrap_d;
        ovf_q   <= ovf_d;
    end

    // Kept combinational so a following stage can use it as its enable.
    assign TC   = E & ~LD & ~CLR & at_bound;
    assign Q    = count_q;
    assign WRAP = wrap_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_sync_updown_mod_counter.sv
// Scoreboard bench: a driver pushes model predictions per cycle, a monitor
// pops and compares them against several counter configurations and a cascade.
module tb_sync_updown_mod_counter;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       ld  = 1'b0;
    logic       e   = 1'b0;
    logic       up  = 1'b0;
    logic [3:0] d   = '0;
    logic       c_e = 1'b0;

    logic [3:0] q_w, q_s, q_lo, q_hi;
    logic [1:0] q_2;
    logic       tc_w, wrap_w, ovf_w;
    logic       tc_s, wrap_s, ovf_s;
    logic       tc_2, wrap_2, ovf_2;
    logic       tc_lo, wrap_lo, ovf_lo;
    logic       tc_hi, wrap_hi, ovf_hi;

    always #5 clk = ~clk;

    sync_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_w (
        .CLK(clk), .CLR(clr), .E(e), .UP(up), .LD(ld), .D(d),
        .Q(q_w), .TC(tc_w), .WRAP(wrap_w), .OVF(ovf_w));

    sync_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s (
        .CLK(clk), .CLR(clr), .E(e), .UP(up), .LD(ld), .D(d),
        .Q(q_s), .TC(tc_s), .WRAP(wrap_s), .OVF(ovf_s));

    sync_updown_mod_counter #(.WIDTH(2), .MODULUS(2), .SATURATE(0)) dut_2 (
        .CLK(clk), .CLR(clr), .E(e), .UP(up), .LD(ld), .D(d[1:0]),
        .Q(q_2), .TC(tc_2), .WRAP(wrap_2), .OVF(ovf_2));

    sync_updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_lo (
        .CLK(clk), .CLR(clr), .E(c_e), .UP(1'b1), .LD(1'b0), .D(4'd0),
        .Q(q_lo), .TC(tc_lo), .WRAP(wrap_lo), .OVF(ovf_lo));

    sync_updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_hi (
        .CLK(clk), .CLR(clr), .E(tc_lo), .UP(1'b1), .LD(1'b0), .D(4'd0),
        .Q(q_hi), .TC(tc_hi), .WRAP(wrap_hi), .OVF(ovf_hi));

    typedef struct {
        int qw; bit ww, ow, tw;
        int qs; bit ws, os, ts;
        int q2; bit w2, o2, t2;
        int cv; bit cw, co, ctc;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   drv_done = 1'b0;

    // Reference model state
    int   mqw, mqs, mq2, mcnt;
    bit   mww, mow, mws, mos, mw2, mo2, mcw, mco;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // One counter stage, from the behavioural rules.
    task automatic mstep(input int m, input bit sat, input bit c, input bit l,
                         input bit en, input bit u, input int dv,
                         inout int q, inout bit w, inout bit o);
        bit bound;
        w = 1'b0;
        if (c) begin
            q = 0; o = 1'b0;
        end else if (l) begin
            q = (dv > m - 1) ? m - 1 : dv; o = 1'b0;
        end else if (en) begin
            bound = u ? (q == m - 1) : (q == 0);
            if (bound) o = 1'b1;
            if (sat) q = u ? ((q + 1 > m - 1) ? m - 1 : q + 1) : ((q == 0) ? 0 : q - 1);
            else begin
                w = bound;
                q = (q + (u ? 1 : m - 1)) % m;
            end
        end
    endtask

    function automatic bit tcf(input int m, input bit c, input bit l,
                               input bit en, input bit u, input int q);
        return en && !l && !c && ((u && q == m - 1) || (!u && q == 0));
    endfunction

    // Advance the model over the coming edge, then apply the next inputs.
    task automatic cyc(input bit n_clr, input bit n_ld, input bit n_e,
                       input bit n_up, input int n_d, input bit n_ce);
        exp_t x;
        @(posedge clk);
        mstep(10, 1'b0, clr, ld, e, up, int'(d), mqw, mww, mow);
        mstep(10, 1'b1, clr, ld, e, up, int'(d), mqs, mws, mos);
        mstep(2,  1'b0, clr, ld, e, up, int'(d[1:0]), mq2, mw2, mo2);
        if (clr) begin
            mcnt = 0; mcw = 1'b0; mco = 1'b0;
        end else begin
            mcw = c_e && (mcnt == 255);
            if (mcw) mco = 1'b1;
            if (c_e) mcnt = (mcnt + 1) % 256;
        end
        #1;
        clr = n_clr; ld = n_ld; e = n_e; up = n_up; d = 4'(n_d); c_e = n_ce;
        x.qw = mqw; x.ww = mww; x.ow = mow; x.tw = tcf(10, clr, ld, e, up, mqw);
        x.qs = mqs; x.ws = mws; x.os = mos; x.ts = tcf(10, clr, ld, e, up, mqs);
        x.q2 = mq2; x.w2 = mw2; x.o2 = mo2; x.t2 = tcf(2, clr, ld, e, up, mq2);
        x.cv = mcnt; x.cw = mcw; x.co = mco;
        x.ctc = c_e && !clr && ((mcnt % 16) == 15);
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("w_q", int'(q_w), x.qw);     chk("w_wrap", int'(wrap_w), int'(x.ww));
                chk("w_ovf", int'(ovf_w), int'(x.ow)); chk("w_tc", int'(tc_w), int'(x.tw));
                chk("s_q", int'(q_s), x.qs);     chk("s_wrap", int'(wrap_s), int'(x.ws));
                chk("s_ovf", int'(ovf_s), int'(x.os)); chk("s_tc", int'(tc_s), int'(x.ts));
                chk("m2_q", int'(q_2), x.q2);    chk("m2_wrap", int'(wrap_2), int'(x.w2));
                chk("m2_ovf", int'(ovf_2), int'(x.o2)); chk("m2_tc", int'(tc_2), int'(x.t2));
                chk("cas_val", int'({q_hi, q_lo}), x.cv);
                chk("cas_hi_wrap", int'(wrap_hi), int'(x.cw));
                chk("cas_hi_ovf", int'(ovf_hi), int'(x.co));
                chk("cas_lo_tc", int'(tc_lo), int'(x.ctc));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

    int hi_wraps_seen = 0;
    always @(negedge clk) if (wrap_hi) hi_wraps_seen++;

    initial begin : driver
        int wraps_before;
        // 1: count up from reset through a wrap
        for (int i = 0; i < 12; i++) cyc(0, 0, 1, 1, 0, 0);
        // 2: load 2, count down through the wrap
        cyc(0, 1, 0, 0, 2, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0);
        // 3: load 8, saturate upward then downward
        cyc(0, 1, 0, 0, 8, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0, 0);
        // 4: clamp with E ignored, then CLR beats LD
        cyc(0, 1, 1, 1, 13, 0);
        cyc(1, 1, 0, 0, 5, 0);
        cyc(0, 0, 0, 0, 0, 0);
        // 5: reset while counting with OVF set
        for (int i = 0; i < 12; i++) cyc(0, 0, 1, 1, 0, 0);
        cyc(1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0, 0);
        // 6: full-range cascade
        cyc(1, 0, 0, 0, 0, 0);
        wraps_before = hi_wraps_seen;
        for (int i = 0; i < 258; i++) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("cas_hi_wrap_count", hi_wraps_seen - wraps_before, 1);
        // randomized traffic on every instance
        for (int i = 0; i < 1500; i++)
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 3) != 0), 1'($urandom), int'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0));
        cyc(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        drv_done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sync_updown_mod_counter.md
Name: sync_updown_mod_counter

Overview:
Parametrised synchronous up/down counter with programmable modulus, parallel load, wrap/saturate mode and terminal-count/overflow flags. It succeeds the fixed 4-bit up counter and serves as the general-purpose counter for timers, dividers and sequencers in the lab designs. The design is fully synchronous on one clock.

Parameters:
WIDTH, 4, counter width in bits; legal range 2..16.
MODULUS, 16, number of count states, so Q runs over 0..MODULUS-1; legal range 2..2**WIDTH.
SATURATE, 0, 0 = wrap at the bounds; 1 = hold at the bound.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
CLR  input  1  reset, synchronous and active-high; clears all state.
E  input  1  count enable.
UP  input  1  direction; 1 = increment, 0 = decrement.
LD  input  1  synchronous parallel load.
D  input  WIDTH  load value.
Q  output  WIDTH  current count (registered).
TC  output  1  terminal count (combinational).
WRAP  output  1  registered one-cycle pulse after a wrap.
OVF  output  1  sticky overflow flag (registered).

Behaviour:
- Reset: when CLR=1 at a rising edge, Q=0, WRAP=0 and OVF=0 on the next cycle. CLR overrides LD and E.
- Priority at each edge is CLR > LD > E. If none of these is asserted, Q holds and WRAP=0.
- Load (LD=1, CLR=0):
  - Q <= D if D <= MODULUS-1; otherwise Q <= MODULUS-1 (clamped).
  - WRAP <= 0 and OVF <= 0. A load clears the sticky flag.
  - E is ignored in the load cycle.
- Count (E=1, LD=0, CLR=0):
  - UP=1 and Q < MODULUS-1: Q <= Q+1.
  - UP=0 and Q > 0: Q <= Q-1.
- Bound, UP=1 and Q = MODULUS-1:
  - SATURATE=0: Q <= 0, WRAP <= 1, OVF <= 1.
  - SATURATE=1: Q holds, WRAP <= 0, OVF <= 1.
- Bound, UP=0 and Q = 0:
  - SATURATE=0: Q <= MODULUS-1, WRAP <= 1, OVF <= 1.
  - SATURATE=1: Q holds, WRAP <= 0, OVF <= 1.
- WRAP is high for exactly the one cycle following the wrapping edge. Back-to-back wraps (MODULUS=2 with E held) produce WRAP high on consecutive cycles.
- OVF, once set, stays high until CLR or LD.
- TC = E & ~LD & ~CLR & ((UP & Q==MODULUS-1) | (~UP & Q==0)). It is combinational, so a higher stage can cascade it as that stage's E, the same way as the ripple-enable chain in the existing counter.
- The UP direction may change on any cycle, and the new direction takes effect at the same edge.
- Arithmetic is performed in WIDTH bits. The modulus compare uses the constant MODULUS-1, so no overflow beyond WIDTH bits is possible.
- When MODULUS = 2**WIDTH, the clamp on load is never active.
- Q never holds a value ≥ MODULUS after the first edge following CLR.
- Illegal parameter values are rejected at elaboration with a generate-time error.

Test Plan:
1. Reset and count up, WIDTH=4, MODULUS=10, SATURATE=0. Apply CLR=1 for one edge, then E=1, UP=1 for 12 edges.
   -> Q runs 0,1,…,9,0,1.
   -> TC is high while Q=9.
   -> WRAP is high for exactly the one cycle with Q=0 after 9.
   -> OVF goes to 1 and stays there.
2. Down wrap, same configuration. Load D=2 with LD=1, then E=1, UP=0 for 4 edges.
   -> Q runs 2,1,0,9,8.
   -> WRAP pulses once, in the cycle Q=9.
   -> OVF is cleared by the load and set at the wrap.
3. Saturate, SATURATE=1, MODULUS=10. Load 8, then UP=1, E=1 for 4 edges.
   -> Q runs 8,9,9,9.
   -> WRAP stays 0 throughout.
   -> OVF rises after the first edge with Q held at 9.
   -> Then UP=0 for 10 edges: Q reaches 0 and holds.
4. Load clamp and priority, MODULUS=10. Drive LD=1, D=13, E=1, UP=1.
   -> Q=9 (clamped, E ignored).
   -> Next edge, CLR=1 and LD=1 with D=5: Q=0 (CLR wins).
5. Reset mid-operation. While counting with OVF=1, assert CLR for one edge with E=1.
   -> Q=0, WRAP=0, OVF=0 on the next cycle.
   -> Counting resumes from 0 once CLR drops.
6. Full-range cascade, WIDTH=4, MODULUS=16, two instances. Drive the upper stage's E from the lower stage's TC, and run 256 edges with E=1, UP=1.
   -> The combined count steps 0..255 and returns to 0.
   -> The upper stage's WRAP pulses once.
